// File: rtl/rf_host_ctrl.sv
// Command-driven host controller for a regfile: serializes read, write, fetch-and-add and
// clear-all commands onto the write port and read port 0, and returns read data on a response channel.
module rf_host_ctrl #(
  parameter int unsigned BW_DATA = 32,
  parameter int unsigned BW_ADDR = 5
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  input  logic               i_cmd_valid,
  output logic               o_cmd_ready,
  input  logic [1:0]         i_cmd_op,
  input  logic [BW_ADDR-1:0] i_cmd_addr,
  input  logic [BW_DATA-1:0] i_cmd_data,
  output logic               o_rsp_valid,
  input  logic               i_rsp_ready,
  output logic [BW_DATA-1:0] o_rsp_data,
  output logic [BW_ADDR-1:0] o_rf_rd_addr0,
  input  logic [BW_DATA-1:0] i_rf_rd_data0,
  output logic [BW_ADDR-1:0] o_rf_wr_addr,
  output logic [BW_DATA-1:0] o_rf_wr_data,
  output logic               o_rf_wr_en
);

  typedef enum logic [1:0] {StIdle, StExec, StRsp, StClear} state_e;

  localparam logic [1:0] OpRead  = 2'b00;
  localparam logic [1:0] OpWrite = 2'b01;
  localparam logic [1:0] OpFadd  = 2'b10;
  localparam logic [1:0] OpClear = 2'b11;

  localparam logic [BW_ADDR-1:0] ClrLast = '1;
  localparam logic [BW_ADDR-1:0] ClrOne  = 1;

  state_e               state_q;
  logic [1:0]           op_q;
  logic [BW_ADDR-1:0]   addr_q;
  logic [BW_DATA-1:0]   data_q;
  logic [BW_DATA-1:0]   rsp_q;
  logic [BW_ADDR-1:0]   clr_cnt_q;

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q   <= StIdle;
      op_q      <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      rsp_q     <= '0;
      clr_cnt_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (i_cmd_valid) begin
            op_q   <= i_cmd_op;
            addr_q <= i_cmd_addr;
            data_q <= i_cmd_data;
            if (i_cmd_op == OpClear) begin
              clr_cnt_q <= '0;
              state_q   <= StClear;
            end else begin
              state_q <= StExec;
            end
          end
        end
        StExec: begin
          // Read and fetch-and-add both return the value seen before any write this cycle.
          if (op_q == OpWrite) begin
            state_q <= StIdle;
          end else begin
            rsp_q   <= i_rf_rd_data0;
            state_q <= StRsp;
          end
        end
        StRsp: begin
          if (i_rsp_ready) state_q <= StIdle;
        end
        StClear: begin
          clr_cnt_q <= clr_cnt_q + ClrOne;
          if (clr_cnt_q == ClrLast) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign o_cmd_ready   = (state_q == StIdle);
  assign o_rsp_valid   = (state_q == StRsp);
  assign o_rsp_data    = rsp_q;
  assign o_rf_rd_addr0 = addr_q;

  always_comb begin
    o_rf_wr_en   = 1'b0;
    o_rf_wr_addr = addr_q;
    o_rf_wr_data = data_q;
    unique case (state_q)
      StExec: begin
        o_rf_wr_en = (op_q != OpRead);
        if (op_q == OpFadd) o_rf_wr_data = i_rf_rd_data0 + data_q;
      end
      StClear: begin
        o_rf_wr_en   = 1'b1;
        o_rf_wr_addr = clr_cnt_q;
        o_rf_wr_data = '0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rf_host_ctrl.sv
// Directed bench for rf_host_ctrl: attached regfile array, a command-level expectation queue
// checked every cycle, and literal expectations for the documented scenarios.
module tb_rf_host_ctrl;

  logic        clk;
  logic        rstn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [4:0]  cmd_addr;
  logic [31:0] cmd_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [4:0]  rd_addr0;
  logic [31:0] rd_data0;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        wr_en;

  rf_host_ctrl #(.BW_DATA(32), .BW_ADDR(5)) dut (
    .i_clk(clk), .i_rstn(rstn),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_op(cmd_op),
    .i_cmd_addr(cmd_addr), .i_cmd_data(cmd_data),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_data(rsp_data),
    .o_rf_rd_addr0(rd_addr0), .i_rf_rd_data0(rd_data0),
    .o_rf_wr_addr(wr_addr), .o_rf_wr_data(wr_data), .o_rf_wr_en(wr_en)
  );

  // Attached register file: asynchronous read, synchronous write, no reset.
  logic [31:0] rf [32];
  assign rd_data0 = rf[rd_addr0];
  always @(posedge clk) if (wr_en) rf[wr_addr] <= wr_data;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, got, exp);
    end
  endtask

  // Model: expected contents plus a queue of per-cycle expectations for a busy command.
  typedef struct {
    logic        wr;
    logic [4:0]  a;
    logic [31:0] d;
    logic        rsp;
    logic [31:0] rv;
  } step_t;

  step_t       q[$];
  step_t       ms;
  logic [31:0] exp_mem [32];
  logic        rsp_pend = 1'b0;
  logic [31:0] last_rsp = '0;
  logic [4:0]  last_addr = '0;
  logic        model_ok = 1'b0;
  logic        idle_b, rspst_b;

  always @(posedge clk) begin
    idle_b  = (q.size() == 0) && !rsp_pend;
    rspst_b = (q.size() == 0) && rsp_pend;
    if (q.size() > 0) begin
      ms = q.pop_front();
      if (ms.wr) exp_mem[ms.a] = ms.d;
      if (ms.rsp) begin
        rsp_pend = 1'b1;
        last_rsp = ms.rv;
      end
    end
    if (!rstn) begin
      q.delete();
      rsp_pend  = 1'b0;
      last_rsp  = '0;
      last_addr = '0;
      model_ok  = 1'b1;
    end else if (model_ok) begin
      if (rspst_b && rsp_ready) rsp_pend = 1'b0;
      if (idle_b && cmd_valid) begin
        last_addr = cmd_addr;
        ms = '{wr: 1'b0, a: cmd_addr, d: cmd_data, rsp: 1'b0, rv: '0};
        case (cmd_op)
          2'b00: begin ms.rsp = 1'b1; ms.rv = exp_mem[cmd_addr]; q.push_back(ms); end
          2'b01: begin ms.wr = 1'b1; q.push_back(ms); end
          2'b10: begin
            ms.wr = 1'b1; ms.rsp = 1'b1; ms.rv = exp_mem[cmd_addr];
            ms.d = exp_mem[cmd_addr] + cmd_data;
            q.push_back(ms);
          end
          default: begin
            for (int k = 0; k < 32; k++) begin
              ms = '{wr: 1'b1, a: 5'(k), d: '0, rsp: 1'b0, rv: '0};
              q.push_back(ms);
            end
          end
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      if (q.size() > 0) begin
        chk("cyc_ready", {31'd0, cmd_ready}, 32'd0);
        chk("cyc_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("cyc_wr_en", {31'd0, wr_en}, {31'd0, q[0].wr});
        if (q[0].wr) begin
          chk("cyc_wr_addr", {27'd0, wr_addr}, {27'd0, q[0].a});
          chk("cyc_wr_data", wr_data, q[0].d);
        end
      end else begin
        chk("cyc_ready", {31'd0, cmd_ready}, {31'd0, !rsp_pend});
        chk("cyc_rsp_valid", {31'd0, rsp_valid}, {31'd0, rsp_pend});
        chk("cyc_wr_en", {31'd0, wr_en}, 32'd0);
      end
      chk("cyc_rsp_data", rsp_data, last_rsp);
      chk("cyc_rd_addr", {27'd0, rd_addr0}, {27'd0, last_addr});
    end
  end

  task automatic issue(input logic [1:0] op, input logic [4:0] a, input logic [31:0] d);
    logic acc;
    acc = 1'b0;
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_data = d;
    for (int i = 0; i < 100 && !acc; i++) begin
      @(negedge clk);
      acc = cmd_ready;
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    if (!acc) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] d);
    issue(2'b01, a, d);
    @(posedge clk); #1;
  endtask

  // Read or fetch-and-add with rsp_ready high; response expected exactly at T+2.
  task automatic do_rsp(input string name, input logic [1:0] op, input logic [4:0] a,
                        input logic [31:0] d, input logic [31:0] exp);
    issue(op, a, d);
    @(negedge clk);
    chk({name, "_exec_valid"}, {31'd0, rsp_valid}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk({name, "_valid"}, {31'd0, rsp_valid}, 32'd1);
    chk({name, "_data"}, rsp_data, exp);
    @(posedge clk); #1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (cmd_ready) break;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  task automatic b2b(input string name, input logic [1:0] op, input int n, input int gap);
    int prev, got;
    prev = -1; got = 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = 5'd20; cmd_data = 32'h55;
    for (int i = 0; i < 60 && got < n; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        if (prev >= 0) chk({name, "_gap"}, 32'(cyc - prev), 32'(gap));
        prev = cyc;
        got++;
      end
      @(posedge clk); #1;
      if (got == n) cmd_valid = 1'b0;
    end
    cmd_valid = 1'b0;
    chk({name, "_count"}, 32'(got), 32'(n));
    wait_idle();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      rf[i] = '0;
      exp_mem[i] = '0;
    end
    rstn = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_data = '0;
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
    chk("rst_rd_addr", {27'd0, rd_addr0}, 32'd0);
    chk("rst_wr_addr", {27'd0, wr_addr}, 32'd0);
    chk("rst_wr_data", wr_data, 32'd0);
    @(posedge clk); #1;
    rstn = 1'b1;

    // Single write pulse, then read back.
    issue(2'b01, 5'd3, 32'hDEADBEEF);
    @(negedge clk);
    chk("wr_pulse_en", {31'd0, wr_en}, 32'd1);
    chk("wr_pulse_addr", {27'd0, wr_addr}, 32'd3);
    @(posedge clk); #1;
    @(negedge clk);
    chk("wr_pulse_end", {31'd0, wr_en}, 32'd0);
    chk("wr_ready_t2", {31'd0, cmd_ready}, 32'd1);
    @(posedge clk); #1;
    do_rsp("rd3", 2'b00, 5'd3, 32'd0, 32'hDEADBEEF);

    // Fetch-and-add, including modular wrap.
    do_write(5'd7, 32'd10);
    do_rsp("faa7", 2'b10, 5'd7, 32'd5, 32'd10);
    do_rsp("rd7", 2'b00, 5'd7, 32'd0, 32'd15);
    do_write(5'd9, 32'hFFFFFFFF);
    do_rsp("faa9", 2'b10, 5'd9, 32'd1, 32'hFFFFFFFF);
    do_rsp("rd9", 2'b00, 5'd9, 32'd0, 32'd0);

    // Response stalled for 4 cycles.
    rsp_ready = 1'b0;
    issue(2'b00, 5'd7, 32'd0);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) rsp_ready = 1'b1;
      @(negedge clk);
      chk("stall_valid", {31'd0, rsp_valid}, 32'd1);
      chk("stall_data", rsp_data, 32'd15);
      chk("stall_ready", {31'd0, cmd_ready}, 32'd0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("stall_release", {31'd0, cmd_ready}, 32'd1);
    @(posedge clk); #1;

    // Back-to-back with valid held high.
    b2b("b2b_wr", 2'b01, 4, 2);
    b2b("b2b_rd", 2'b00, 3, 3);

    // Fill, then full clear sweep.
    for (int i = 0; i < 32; i++) do_write(5'(i), 32'hA5000000 + 32'(i));
    issue(2'b11, 5'd17, 32'd0);
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      chk("clr_wr_en", {31'd0, wr_en}, 32'd1);
      chk("clr_addr", {27'd0, wr_addr}, 32'(k));
      chk("clr_data", wr_data, 32'd0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("clr_ready_t33", {31'd0, cmd_ready}, 32'd1);
    chk("clr_wr_en_end", {31'd0, wr_en}, 32'd0);
    @(posedge clk); #1;
    for (int i = 0; i < 32; i++) do_rsp("clr_rd", 2'b00, 5'(i), 32'd0, 32'd0);

    // Reset during a clear sweep: entries 0..8 zeroed, 9..31 untouched.
    for (int i = 0; i < 32; i++) do_write(5'(i), 32'h1000 + 32'(i));
    issue(2'b11, 5'd0, 32'd0);
    repeat (8) begin
      @(posedge clk); #1;
    end
    rstn = 1'b0;
    @(negedge clk);
    chk("abort_last_wr", {27'd0, wr_addr}, 32'd8);
    @(posedge clk); #1;
    rstn = 1'b1;
    @(negedge clk);
    chk("abort_wr_en", {31'd0, wr_en}, 32'd0);
    chk("abort_ready", {31'd0, cmd_ready}, 32'd1);
    @(posedge clk); #1;
    do_rsp("abort_rd0", 2'b00, 5'd0, 32'd0, 32'd0);
    do_rsp("abort_rd8", 2'b00, 5'd8, 32'd0, 32'd0);
    do_rsp("abort_rd9", 2'b00, 5'd9, 32'd0, 32'h1009);
    do_rsp("abort_rd31", 2'b00, 5'd31, 32'd0, 32'h101F);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
